booth_seq_mult: RTL and testbench

BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

---
 rtl/booth_seq_mult_pkg.sv | 16 +
 rtl/booth_seq_mult_booth.sv | 30 +++
 rtl/booth_seq_mult.sv | 70 +++++++
 tb/tb_booth_seq_mult.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/booth_seq_mult_pkg.sv
// Shared widths, step count and FSM state encoding for the sequential Booth multiplier.
package booth_seq_mult_pkg;

    localparam int OP_W    = 8;
    localparam int PROD_W  = 2 * OP_W;
    localparam int N_STEPS = 8;
    localparam int CNT_W   = 3;

    // State set: IDLE -> RUN -> DONE -> IDLE
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_STEPS - 1);

endpackage

// File: rtl/booth_seq_mult_booth.sv
// One combinational radix-2 Booth step: add/subtract M by Q[1:0], then shift {A,Q} right.
module booth
    import booth_seq_mult_pkg::*;
(
    input  logic [OP_W-1:0] a_in,
    input  logic [OP_W-1:0] m,
    input  logic [OP_W:0]   q,
    output logic [OP_W-1:0] a_out,
    output logic [OP_W:0]   q_out
);

    logic signed [OP_W:0] a_ext;
    logic signed [OP_W:0] m_ext;
    logic signed [OP_W:0] sum;

    // The sum carries one guard bit so that M=-128 stays exact; the
    // post-shift accumulator always fits back into OP_W bits.
    always_comb begin
        a_ext = {a_in[OP_W-1], a_in};
        m_ext = {m[OP_W-1], m};
        unique case (q[1:0])
            2'b10:   sum = a_ext - m_ext;
            2'b01:   sum = a_ext + m_ext;
            default: sum = a_ext;
        endcase
        a_out = sum[OP_W:1];
        q_out = {sum[0], q[OP_W:1]};
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential signed 8x8 Booth multiplier: one step per clock, valid/ready on both sides.
module booth_seq_mult
    import booth_seq_mult_pkg::*;
#(
    parameter int WIDTH = OP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    logic [1:0]              state;
    logic signed [WIDTH-1:0] a;
    logic signed [WIDTH-1:0] m;
    logic [WIDTH:0]          q;
    logic [CNT_W-1:0]        count;
    logic [WIDTH-1:0]        a_step;
    logic [WIDTH:0]          q_step;

    booth u_booth (
        .a_in  (a),
        .m     (m),
        .q     (q),
        .a_out (a_step),
        .q_out (q_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a     <= '0;
            m     <= '0;
            q     <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a     <= '0;
                        m     <= multiplicand;
                        q     <= {multiplier, 1'b0};
                        count <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a     <= a_step;
                    q     <= q_step;
                    count <= count + 1'b1;
                    if (count == LAST_STEP) state <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign product   = {a, q[WIDTH:1]};

endmodule

// File: tb/tb_booth_seq_mult.sv
// Randomized and directed bench for booth_seq_mult against a plain-multiply reference model.
module tb_booth_seq_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;

    int n_checks = 0;
    int n_pass   = 0;

    booth_seq_mult #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        int sx;
        int sy;
        int p;
        sx = int'($signed(x));
        sy = int'($signed(y));
        p  = sx * sy;
        return p[15:0];
    endfunction

    // Offer one operand pair, stall the consumer for `stall` cycles once the
    // product appears, optionally keep in_valid high with junk operands during RUN.
    task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] exp, input int stall, input bit noisy);
        int lat;
        @(negedge clk);
        in_valid     = 1'b1;
        multiplicand = x;
        multiplier   = y;
        out_ready    = 1'b0;
        chk({tag, ".ready_before"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        if (noisy) begin
            multiplicand = 8'($urandom);
            multiplier   = 8'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        chk({tag, ".ready_run"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (noisy) begin
                multiplicand = 8'($urandom);
                multiplier   = 8'($urandom);
            end
        end
        in_valid = 1'b0;
        chk({tag, ".latency"}, 32'(lat), 32'd8);
        chk({tag, ".product"}, 32'(product), 32'(exp));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_prod"}, 32'(product), 32'(exp));
            chk({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, ".ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] ry;
        int         seen;

        rst          = 1'b1;
        in_valid     = 1'b0;
        multiplicand = 8'h00;
        multiplier   = 8'h00;
        out_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.product", 32'(product), 32'h0000);
        @(negedge clk);
        rst = 1'b0;

        run_op("m3q5", 8'd3, 8'd5, 16'h000F, 0, 1'b0);
        run_op("neg1", 8'hFF, 8'hFF, 16'h0001, 0, 1'b0);
        run_op("min_min", 8'h80, 8'h80, 16'h4000, 0, 1'b0);
        run_op("min_max", 8'h80, 8'h7F, 16'hC080, 0, 1'b0);
        run_op("stall5", 8'h9C, 8'h2B, ref_mul(8'h9C, 8'h2B), 5, 1'b0);
        run_op("noisy", 8'h11, 8'hF3, ref_mul(8'h11, 8'hF3), 0, 1'b1);

        // Abort mid-operation with an asynchronous reset pulse.
        @(negedge clk);
        in_valid     = 1'b1;
        multiplicand = 8'h55;
        multiplier   = 8'h66;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort.out_valid", 32'(out_valid), 32'd0);
        chk("abort.in_ready", 32'(in_ready), 32'd1);
        chk("abort.product", 32'(product), 32'h0000);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst", 8'hF9, 8'h06, 16'hFFD6, 0, 1'b0);

        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("idle.no_valid", 32'(seen), 32'd0);

        for (int i = 0; i < 24; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            run_op($sformatf("rnd%0d", i), rx, ry, ref_mul(rx, ry),
                   int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
